mem_req_sequencer: RTL

//  Upstream request stage for the single-port Memory block. Buffers read/write commands in a small FIFO.

---
 rtl/mem_seq_pkg.sv | 25 ++
 rtl/mem_req_fifo.sv | 47 ++++
 rtl/mem_req_sequencer.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types for the memory request sequencer: FSM states, request record, stats width.
package mem_seq_pkg;

  localparam int STAT_W      = 16;
  localparam int DFLT_ADDR_W = 8;
  localparam int DFLT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } seq_state_e;

  typedef struct packed {
    logic                   rw;
    logic [DFLT_ADDR_W-1:0] addr;
    logic [DFLT_DATA_W-1:0] data;
  } mem_req_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Request FIFO with extra-MSB pointers; storage is unreset, pointers reset synchronously.
module mem_req_fifo
  import mem_seq_pkg::*;
#(
  parameter int  Depth = 4,
  parameter type T     = mem_req_t
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   push,
  input  T                       push_data,
  input  logic                   pop,
  output T                       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(Depth):0] count
);

  localparam int AW = $clog2(Depth);

  T           mem [Depth];
  logic [AW:0] wptr, rptr;
  logic        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rptr[AW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;

endmodule

// File: rtl/mem_req_sequencer.sv
// Queues bus read/write requests and issues them one at a time to a single-port Memory.
// Optional MEM_SEQ_STATS_EN adds saturating write/read issue counters.
module mem_req_sequencer
  import mem_seq_pkg::*;
#(
  parameter int AddrSize  = 8,
  parameter int DataSize  = 32,
  parameter int FifoDepth = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic                ReqRW,
  input  logic [AddrSize-1:0] ReqAddr,
  input  logic [DataSize-1:0] ReqData,
  output logic [DataSize-1:0] MemDin,
  output logic [AddrSize-1:0] MemAddr,
  output logic                MemValid,
  output logic                MemR_W,
  input  logic [DataSize-1:0] MemDout,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [DataSize-1:0] RspData,
  output logic [AddrSize-1:0] RspAddr,
  output logic                Busy
`ifdef MEM_SEQ_STATS_EN
  ,
  output logic [STAT_W-1:0]   WrCount,
  output logic [STAT_W-1:0]   RdCount
`endif
);

  localparam int CW = $clog2(FifoDepth) + 1;

  typedef struct packed {
    logic                rw;
    logic [AddrSize-1:0] addr;
    logic [DataSize-1:0] data;
  } req_t;

  req_t          push_req, head;
  logic          push, pop, full, empty;
  logic [CW-1:0] count;
  logic          rdy_en;

  seq_state_e          state, state_n;
  logic [AddrSize-1:0] mem_addr_n, rsp_addr_n;
  logic [DataSize-1:0] mem_din_n, rsp_data_n;
  logic                mem_valid_n, mem_rw_n, rsp_valid_n;

  // rdy_en keeps ReqReady low through reset; otherwise it tracks the registered full flag only.
  assign ReqReady = rdy_en && !full;
  assign push     = ReqValid && ReqReady;
  assign push_req = '{rw: ReqRW, addr: ReqAddr, data: ReqData};
  assign Busy     = (state != IDLE) || (count != '0);

  mem_req_fifo #(
    .Depth (FifoDepth),
    .T     (req_t)
  ) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    mem_valid_n = 1'b0;
    mem_addr_n  = MemAddr;
    mem_din_n   = MemDin;
    mem_rw_n    = MemR_W;
    rsp_valid_n = RspValid;
    rsp_data_n  = RspData;
    rsp_addr_n  = RspAddr;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop         = 1'b1;
          mem_valid_n = 1'b1;
          mem_addr_n  = head.addr;
          mem_din_n   = head.data;
          mem_rw_n    = head.rw;
          state_n     = ISSUE;
        end
      end
      ISSUE: state_n = MemR_W ? IDLE : WAIT;
      // Memory registered Dout at the end of ISSUE, so it is valid throughout WAIT.
      WAIT: begin
        rsp_valid_n = 1'b1;
        rsp_data_n  = MemDout;
        rsp_addr_n  = MemAddr;
        state_n     = RESP;
      end
      RESP: begin
        if (RspReady) begin
          rsp_valid_n = 1'b0;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      rdy_en   <= 1'b0;
      MemValid <= 1'b0;
      MemAddr  <= '0;
      MemDin   <= '0;
      MemR_W   <= 1'b0;
      RspValid <= 1'b0;
      RspData  <= '0;
      RspAddr  <= '0;
    end else begin
      state    <= state_n;
      rdy_en   <= 1'b1;
      MemValid <= mem_valid_n;
      MemAddr  <= mem_addr_n;
      MemDin   <= mem_din_n;
      MemR_W   <= mem_rw_n;
      RspValid <= rsp_valid_n;
      RspData  <= rsp_data_n;
      RspAddr  <= rsp_addr_n;
    end
  end

`ifdef MEM_SEQ_STATS_EN
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      WrCount <= '0;
      RdCount <= '0;
    end else if (state == ISSUE) begin
      if (MemR_W) WrCount <= sat_inc(WrCount);
      else        RdCount <= sat_inc(RdCount);
    end
  end
`endif

endmodule
